crop_stream_tx: RTL
===================

Name: crop_stream_tx

Overview:
- Transmitter side of the CNN pixel-input stream. Reads a full IN_ROWS x IN_COLS image from a synchronous single-port frame RAM.
- Extracts one OUT_ROWS x OUT_COLS crop whose top-left corner is at (y1, x1).
- Drives the crop in row-major order onto a valid/ready stream that feeds the network's input port (conv2d_1_input data stream).
- Sits between the frame buffer and the HLS CNN core.

Parameters:
- FP_TOTAL, 16, pixel word width in bits.
- IN_ROWS, 100, source image rows.
- IN_COLS, 160, source image columns.
- OUT_ROWS, 48, crop rows.
- OUT_COLS, 48, crop columns.
- ADDR_W, $clog2(IN_ROWS*IN_COLS), frame RAM address width (14 at defaults).
- ROW_W, $clog2(IN_ROWS), width of the y1 input.
- COL_W, $clog2(IN_COLS), width of the x1 input.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- ap_start  in  1  start request; sampled only while ap_idle=1.
- crop_y1  in  ROW_W  crop top row; latched when start is accepted.
- crop_x1  in  COL_W  crop left column; latched when start is accepted.
- ap_idle  out  1  high while in IDLE.
- ap_done  out  1  one-cycle pulse after the final beat is accepted.
- mem_en  out  1  frame RAM read enable.
- mem_addr  out  ADDR_W  frame RAM read address, row-major: row*IN_COLS+col.
- mem_rdata  in  FP_TOTAL  RAM read data; valid exactly 1 cycle after mem_en.
- out_TDATA  out  FP_TOTAL  pixel data.
- out_TVALID  out  1  pixel valid.
- out_TREADY  in  1  downstream ready.
- out_TLAST  out  1  high on the final crop pixel only.

Behaviour:
- Reset values: ap_idle=1, ap_done=0, mem_en=0, mem_addr=0, out_TVALID=0, out_TDATA=0, out_TLAST=0. The state machine resets to IDLE and all counters clear.
- Reset mid-frame: abort immediately. Drop any in-flight RAM read and any buffered data. out_TVALID is 0 in the cycle after ap_rst is sampled high. No ap_done is generated.
- States:
  - IDLE: on ap_start=1, latch clamped y1/x1, clear the row/column counters, go to RUN.
  - RUN: issue reads; after the last address is issued, go to DRAIN.
  - DRAIN: after the last beat handshake, go to DONE.
  - DONE: ap_done=1 for one cycle, then go to IDLE.
- ap_start outside IDLE is ignored.
- Clamping:
  - y1 is replaced by IN_ROWS-OUT_ROWS when y1 > IN_ROWS-OUT_ROWS.
  - x1 is replaced by IN_COLS-OUT_COLS when x1 > IN_COLS-OUT_COLS.
- Address generation:
  - Column counter c runs 0..OUT_COLS-1. On wrap, it returns to 0 and row counter r increments.
  - mem_addr = (y1+r)*IN_COLS + (x1+c). Compute it incrementally: +1 per pixel, and +IN_COLS-OUT_COLS+1 on column wrap. No multiplier in the per-beat path.
- Buffering:
  - 2-entry output FIFO (skid).
  - A read is issued (mem_en=1) only when FIFO occupancy plus in-flight reads is less than 2, so RAM data is never lost under backpressure.
- Handshake:
  - A beat transfers when out_TVALID && out_TREADY on a rising edge.
  - While out_TVALID=1 and out_TREADY=0, out_TDATA and out_TLAST hold stable and out_TVALID stays high.
  - out_TVALID never depends combinationally on out_TREADY.
- Throughput and latency:
  - Start accepted at edge N: the first read is issued in cycle N+1, and out_TVALID rises in cycle N+2.
  - With out_TREADY held high, sustain 1 beat/cycle, with no bubbles at row wraps.
- Beat count: exactly OUT_ROWS*OUT_COLS beats per start. out_TLAST=1 only on beat index OUT_ROWS*OUT_COLS-1.
- Completion and restart:
  - ap_done pulses in the cycle after the last handshake.
  - ap_idle returns high in the following cycle.
  - A new ap_start is accepted in that cycle, with no extra gap.
- out_TREADY held low indefinitely: the block stalls with the FIFO full, no reads are issued, and no state change occurs.

Test Plan:
- Full throughput:
  - Setup: RAM[a]=a, origin (10,10), out_TREADY=1, start accepted at edge N.
  - Expected: 2304 beats from cycle N+2, contiguous. First TDATA=1610. Row-1 first TDATA=1770. Last TDATA=9177 with TLAST=1. ap_done in cycle N+2306.
- Backpressure:
  - Stimulus: out_TREADY=0 for 2*48*48 cycles after start, then 1.
  - Expected: TVALID high with TDATA=1610 stable through the stall, and mem_en=0 once the FIFO is full. Then a gapless, correct sequence; total 2304 beats.
- Random ready:
  - Stimulus: out_TREADY=$urandom%2 per cycle.
  - Expected: the scoreboard matches the expected sequence exactly, with no dropped or duplicated pixel; TLAST only on beat 2303.
- Clamp:
  - Stimulus: origin (90,150).
  - Expected: treated as (52,112). First TDATA=8432, last TDATA=15999.
- Reset mid-frame:
  - Stimulus: assert ap_rst for 1 cycle after beat 1000, then restart at (0,0).
  - Expected: TVALID=0 the next cycle and no ap_done for the aborted frame. The new frame starts at TDATA=0, ends at 7567, and produces 2304 beats.
- Back-to-back:
  - Stimulus: ap_start held high across two frames with origins (10,10) then (0,0).
  - Expected: the second frame's first read is issued 2 cycles after ap_done. ap_start pulses while busy are ignored, giving exactly 2 ap_done pulses.

Source files
------------

// File: rtl/crop_stream_tx.sv
// Crop transmitter: reads an OUT_ROWS x OUT_COLS window of a row-major frame RAM
// and streams it row-major over a valid/ready port, with a 2-entry skid FIFO.
module crop_stream_tx #(
    parameter int FP_TOTAL = 16,
    parameter int IN_ROWS  = 100,
    parameter int IN_COLS  = 160,
    parameter int OUT_ROWS = 48,
    parameter int OUT_COLS = 48,
    parameter int ADDR_W   = $clog2(IN_ROWS * IN_COLS),
    parameter int ROW_W    = $clog2(IN_ROWS),
    parameter int COL_W    = $clog2(IN_COLS)
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    input  logic [ROW_W-1:0]    crop_y1,
    input  logic [COL_W-1:0]    crop_x1,
    output logic                ap_idle,
    output logic                ap_done,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [FP_TOTAL-1:0] mem_rdata,
    output logic [FP_TOTAL-1:0] out_TDATA,
    output logic                out_TVALID,
    input  logic                out_TREADY,
    output logic                out_TLAST
);

    localparam int BEATS   = OUT_ROWS * OUT_COLS;
    localparam int CNT_C_W = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam int CNT_R_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [ROW_W-1:0]   Y1_MAX    = ROW_W'(IN_ROWS - OUT_ROWS);
    localparam logic [COL_W-1:0]   X1_MAX    = COL_W'(IN_COLS - OUT_COLS);
    localparam logic [ADDR_W-1:0]  ROW_STEP  = ADDR_W'(IN_COLS - OUT_COLS + 1);
    localparam logic [CNT_C_W-1:0] COL_LAST  = CNT_C_W'(OUT_COLS - 1);
    localparam logic [CNT_R_W-1:0] ROW_LAST  = CNT_R_W'(OUT_ROWS - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_C_W-1:0]    col_q, col_d;
    logic [CNT_R_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic [FP_TOTAL-1:0]   fifo_q [2];
    logic [FP_TOTAL-1:0]   fifo_d [2];

    logic [ROW_W-1:0]      y1_clamped;
    logic [COL_W-1:0]      x1_clamped;
    logic [ADDR_W-1:0]     start_addr;
    logic [1:0]            occupancy;
    logic [1:0]            wr_idx;
    logic                  issue;
    logic                  tvalid;
    logic                  handshake;
    logic                  pop;
    logic                  push;

    // The only multiply happens once per frame, when the origin is latched.
    always_comb begin
        y1_clamped = (crop_y1 > Y1_MAX) ? Y1_MAX : crop_y1;
        x1_clamped = (crop_x1 > X1_MAX) ? X1_MAX : crop_x1;
        start_addr = ADDR_W'(y1_clamped) * ADDR_W'(IN_COLS) + ADDR_W'(x1_clamped);
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        fifo_d     = fifo_q;

        occupancy  = count_q + {1'b0, inflight_q};
        issue      = (state_q == ST_RUN) && (occupancy < 2'd2);
        tvalid     = (count_q != 2'd0) || inflight_q;
        handshake  = tvalid && out_TREADY;
        // With an empty FIFO the returning RAM word is presented directly and
        // only needs storing if the consumer does not take it this cycle.
        pop        = handshake && (count_q != 2'd0);
        push       = inflight_q && !(handshake && (count_q == 2'd0));
        wr_idx     = count_q - {1'b0, pop};

        if (pop) begin
            fifo_d[0] = fifo_q[1];
        end
        if (push) begin
            if (wr_idx == 2'd0) begin
                fifo_d[0] = mem_rdata;
            end else begin
                fifo_d[1] = mem_rdata;
            end
        end
        count_d    = count_q - {1'b0, pop} + {1'b0, push};
        inflight_d = issue;

        if (handshake) begin
            beat_d = beat_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                    row_d   = '0;
                    beat_d  = '0;
                    addr_d  = start_addr;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    if (col_q == COL_LAST) begin
                        col_d  = '0;
                        row_d  = row_q + 1'b1;
                        addr_d = addr_q + ROW_STEP;
                        if (row_q == ROW_LAST) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        col_d  = col_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (handshake && (beat_q == BEAT_LAST)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            beat_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    assign ap_idle    = (state_q == ST_IDLE);
    assign ap_done    = (state_q == ST_DONE);
    assign mem_en     = issue;
    assign mem_addr   = addr_q;
    assign out_TVALID = tvalid;
    assign out_TDATA  = (count_q != 2'd0) ? fifo_q[0] :
                        (inflight_q ? mem_rdata : '0);
    assign out_TLAST  = tvalid && (beat_q == BEAT_LAST);

endmodule
